// File: rtl/beat_serializer.sv
// beat_serializer: loads one DEPTH-beat word over valid/ready and emits it as WIDTH-bit beats.
// Build option BEAT_SERIALIZER_MSB_FIRST_EN reverses beat order (highest beat first).
module beat_serializer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*DEPTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic                   busy
);

  localparam int WW = WIDTH * DEPTH;
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  if (DEPTH < 1 || WIDTH < 1) begin : g_bad_param
    $error("beat_serializer: DEPTH and WIDTH must both be >= 1");
  end

  typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [WW-1:0]   r_word;
  logic [WIDTH-1:0] r_out_data;
  logic            r_out_valid;
  logic            r_out_last;

  logic            w_out_fire;
  logic            w_in_fire;
  logic [CW-1:0]   w_cnt_next;
  logic [WIDTH-1:0] w_load_beat;
  logic [WW-1:0]   w_load_rest;
  logic [WIDTH-1:0] w_next_beat;
  logic [WW-1:0]   w_next_rest;

  // r_word holds only the beats not yet presented, aligned so the next one sits at the emit end.
`ifdef BEAT_SERIALIZER_MSB_FIRST_EN
  assign w_load_beat = in_data[WW-1 -: WIDTH];
  assign w_load_rest = in_data << WIDTH;
  assign w_next_beat = r_word[WW-1 -: WIDTH];
  assign w_next_rest = r_word << WIDTH;
`else
  assign w_load_beat = in_data[WIDTH-1:0];
  assign w_load_rest = in_data >> WIDTH;
  assign w_next_beat = r_word[WIDTH-1:0];
  assign w_next_rest = r_word >> WIDTH;
`endif

  assign w_out_fire = r_out_valid & out_ready;
  // Combinational out_ready -> in_ready path lets a new word load with no bubble.
  assign in_ready   = (r_state == S_IDLE) | (w_out_fire & (r_cnt == LAST));
  assign w_in_fire  = in_valid & in_ready;
  assign w_cnt_next = r_cnt + CW'(1);

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_word      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_fire) begin
            r_state     <= S_SHIFT;
            r_cnt       <= '0;
            r_word      <= w_load_rest;
            r_out_data  <= w_load_beat;
            r_out_valid <= 1'b1;
            r_out_last  <= (LAST == '0);
          end
        end
        S_SHIFT: begin
          if (w_out_fire) begin
            if (r_cnt != LAST) begin
              r_cnt      <= w_cnt_next;
              r_word     <= w_next_rest;
              r_out_data <= w_next_beat;
              r_out_last <= (w_cnt_next == LAST);
            end else if (w_in_fire) begin
              r_cnt       <= '0;
              r_word      <= w_load_rest;
              r_out_data  <= w_load_beat;
              r_out_valid <= 1'b1;
              r_out_last  <= (LAST == '0);
            end else begin
              r_state     <= S_IDLE;
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beat_serializer.sv
// Self-checking bench for beat_serializer (DEPTH=4, WIDTH=4) against a queue-based beat model.
// Honours BEAT_SERIALIZER_MSB_FIRST_EN the same way the design does.
module tb_beat_serializer;

  localparam int DEPTH = 4;
  localparam int WIDTH = 4;
  localparam int WW    = DEPTH * WIDTH;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [WW-1:0]   in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic            out_last;
  logic            busy;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  typedef struct packed {
    logic             valid;
    logic             last;
    logic [WIDTH-1:0] data;
    logic             rdy;
    logic             bsy;
  } snap_t;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] emitted[$];

  beat_serializer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] beat_of(input logic [WW-1:0] w, input int k);
`ifdef BEAT_SERIALIZER_MSB_FIRST_EN
    return w[(DEPTH-1-k)*WIDTH +: WIDTH];
`else
    return w[k*WIDTH +: WIDTH];
`endif
  endfunction

  // Drive one cycle's inputs, sample outputs, and advance the model: a word accepted
  // becomes DEPTH queued beats; the head beat is what must be on the output.
  task automatic cycle(input logic iv, input logic [WW-1:0] id, input logic ordy,
                       output snap_t obs, output snap_t exp);
    @(negedge clk);
    in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    cyc++;
    exp.valid = (q.size() != 0);
    exp.last  = (q.size() == 1);
    exp.data  = exp.valid ? q[0] : '0;
    exp.rdy   = (q.size() == 0) || (ordy && q.size() == 1);
    exp.bsy   = exp.valid;
    obs.valid = out_valid;
    obs.last  = out_last;
    obs.data  = exp.valid ? out_data : '0;
    obs.rdy   = in_ready;
    obs.bsy   = busy;
    if (exp.valid && ordy) begin
      emitted.push_back(out_data);
      void'(q.pop_front());
    end
    if (iv && exp.rdy)
      for (int k = 0; k < DEPTH; k++) q.push_back(beat_of(id, k));
  endtask

  task automatic test_reset();
    snap_t o, e;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 16'h4321, 1'b0, o, e);
    tests++;
    if (o !== e) begin
      failed++;
      $display("FAIL reset_accept cyc %0d got %h expected %h", cyc, o, e);
    end
    cycle(1'b0, 16'h0, 1'b0, o, e);
    tests++;
    if (o !== e) begin
      failed++;
      $display("FAIL reset_prehold cyc %0d got %h expected %h", cyc, o, e);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({out_valid, out_last, busy, out_data} !== 7'b0) begin
      failed++;
      $display("FAIL reset_async got v=%0b l=%0b b=%0b d=%h expected all 0",
               out_valid, out_last, busy, out_data);
    end
    q.delete(); emitted.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_in_ready got %0b expected 1", in_ready);
    end
  endtask

  task automatic test_single();
    snap_t o, e;
    logic [WIDTH-1:0] want[$];
    logic ok;
`ifdef BEAT_SERIALIZER_MSB_FIRST_EN
    want = '{4'h4, 4'h3, 4'h2, 4'h1};
`else
    want = '{4'h1, 4'h2, 4'h3, 4'h4};
`endif
    emitted.delete();
    for (int i = 0; i < 6; i++) begin
      cycle(i == 0, (i == 0) ? 16'h4321 : 16'h0, 1'b1, o, e);
      tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL single cyc %0d got %h expected %h", cyc, o, e);
      end
    end
    ok = (emitted.size() == want.size());
    if (ok) for (int i = 0; i < want.size(); i++) if (emitted[i] !== want[i]) ok = 1'b0;
    tests++;
    if (!ok) begin
      failed++;
      $display("FAIL single_seq got %0d beats %p expected %p", emitted.size(), emitted, want);
    end
  endtask

  task automatic test_back_to_back();
    snap_t o, e;
    logic [WIDTH-1:0] want[$];
    logic ok;
`ifdef BEAT_SERIALIZER_MSB_FIRST_EN
    want = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5};
`else
    want = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
`endif
    emitted.delete();
    for (int i = 0; i < 10; i++) begin
      cycle(i < 5, (i == 0) ? 16'h4321 : 16'h8765, 1'b1, o, e);
      tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL b2b cyc %0d got %h expected %h", cyc, o, e);
      end
    end
    ok = (emitted.size() == want.size());
    if (ok) for (int i = 0; i < want.size(); i++) if (emitted[i] !== want[i]) ok = 1'b0;
    tests++;
    if (!ok) begin
      failed++;
      $display("FAIL b2b_seq got %0d beats %p expected %p", emitted.size(), emitted, want);
    end
  endtask

  task automatic test_backpressure();
    snap_t o, e;
    logic [WIDTH-1:0] want[$];
    logic ok;
`ifdef BEAT_SERIALIZER_MSB_FIRST_EN
    want = '{4'h4, 4'h3, 4'h2, 4'h1};
`else
    want = '{4'h1, 4'h2, 4'h3, 4'h4};
`endif
    emitted.delete();
    cycle(1'b1, 16'h4321, 1'b1, o, e);
    for (int i = 0; i < 8; i++) begin
      // cycles 1..3 stall the second beat while an ignored word is offered
      cycle(i >= 1 && i <= 3, 16'hFFFF, !(i >= 1 && i <= 3), o, e);
      tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL backpressure cyc %0d got %h expected %h", cyc, o, e);
      end
    end
    ok = (emitted.size() == want.size());
    if (ok) for (int i = 0; i < want.size(); i++) if (emitted[i] !== want[i]) ok = 1'b0;
    tests++;
    if (!ok) begin
      failed++;
      $display("FAIL backpressure_seq got %0d beats %p expected %p", emitted.size(), emitted, want);
    end
  endtask

  task automatic test_mid_reset();
    snap_t o, e;
    logic [WIDTH-1:0] want[$];
    logic ok;
`ifdef BEAT_SERIALIZER_MSB_FIRST_EN
    want = '{4'hC, 4'hB, 4'hA, 4'h9};
`else
    want = '{4'h9, 4'hA, 4'hB, 4'hC};
`endif
    cycle(1'b1, 16'h4321, 1'b1, o, e);
    cycle(1'b0, 16'h0, 1'b1, o, e);
    cycle(1'b0, 16'h0, 1'b0, o, e);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({out_valid, out_last, busy, out_data} !== 7'b0) begin
      failed++;
      $display("FAIL midreset_async got v=%0b l=%0b b=%0b d=%h expected all 0",
               out_valid, out_last, busy, out_data);
    end
    q.delete(); emitted.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle(i == 0, 16'hCBA9, 1'b1, o, e);
      tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL midreset cyc %0d got %h expected %h", cyc, o, e);
      end
    end
    ok = (emitted.size() == want.size());
    if (ok) for (int i = 0; i < want.size(); i++) if (emitted[i] !== want[i]) ok = 1'b0;
    tests++;
    if (!ok) begin
      failed++;
      $display("FAIL midreset_seq got %0d beats %p expected %p", emitted.size(), emitted, want);
    end
  endtask

  task automatic test_random();
    snap_t o, e;
    logic [WW-1:0] word;
    logic hold, iv, ordy;
    int accepted, drained;
    hold = 1'b0; word = '0; accepted = 0;
    emitted.delete();
    for (int i = 0; i < 400; i++) begin
      if (!hold) word = WW'($urandom);
      iv   = hold ? 1'b1 : ($urandom_range(0, 2) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      cycle(iv, word, ordy, o, e);
      tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL random cyc %0d got %h expected %h", cyc, o, e);
      end
      if (iv && e.rdy) accepted++;
      hold = iv && !e.rdy;
    end
    for (int i = 0; i < DEPTH + 1; i++) begin
      cycle(1'b0, '0, 1'b1, o, e);
      tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL random_drain cyc %0d got %h expected %h", cyc, o, e);
      end
    end
    drained = emitted.size();
    tests++;
    if (drained != accepted * DEPTH) begin
      failed++;
      $display("FAIL random_count got %0d beats expected %0d", drained, accepted * DEPTH);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/beat_serializer.md
Name: beat_serializer

Overview:
- Parallel-to-serial converter for the beat-accumulation path; it is the transmit-side counterpart of beat_shift_register.
- Accepts one DEPTH-beat word (WIDTH*DEPTH bits) over a valid/ready handshake and emits it as DEPTH consecutive WIDTH-bit beats on a second valid/ready handshake.
- Sits between a word-wide producer and a narrow beat link. Supports back-to-back words with no idle cycle between the last beat of one word and the first beat of the next.

Parameters:
- DEPTH, 4, beats per word; must be >= 1 (elaboration error otherwise).
- WIDTH, 4, bits per beat; must be >= 1.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  block can accept a word this cycle (combinational).
- in_data  input  WIDTH*DEPTH  word to serialize; beat k = in_data[k*WIDTH +: WIDTH].
- out_valid  output  1  out_data holds a valid beat (registered).
- out_ready  input  1  consumer accepts the current beat.
- out_data  output  WIDTH  current beat (registered).
- out_last  output  1  current beat is the final beat of its word (registered).
- busy  output  1  a word is in flight; equals out_valid.

Behaviour:
- Reset: takes effect immediately on rst high, regardless of clk.
  - out_valid = 0, out_data = 0, out_last = 0, busy = 0.
  - Beat counter = 0; state = IDLE.
  - Any word in flight is discarded; no partial word resumes after reset.
- States:
  - IDLE (no word held).
  - SHIFT (word held; beat counter cnt in 0..DEPTH-1 marks the presented beat).
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = (state == IDLE) | (out_fire & cnt == DEPTH-1). This is a combinational path from out_ready to in_ready and is intentional.
- IDLE:
  - On in_fire, latch in_data into the shift register, present beat 0 next cycle (out_valid = 1, cnt = 0), go to SHIFT.
  - Latency from the accept edge to the first beat visible = 1 cycle.
- SHIFT:
  - out_data and out_last stay stable while out_valid & !out_ready.
  - On out_fire with cnt < DEPTH-1: present the next beat, cnt+1.
  - On out_fire with cnt == DEPTH-1 and in_fire: load the new word and present its beat 0 next cycle (no bubble); remain in SHIFT.
  - On out_fire with cnt == DEPTH-1 and no in_fire: out_valid = 0, out_last = 0, go to IDLE.
- out_last = 1 exactly when cnt == DEPTH-1 and out_valid. With DEPTH = 1, every beat has out_last = 1 and the block is a 1-entry register slice.
- in_valid while in_ready = 0 is ignored; the producer must hold its word (standard valid/ready rules).
- out_data returns to 0 only on reset; its value when out_valid = 0 is don't-care for the consumer.
- Throughput: one beat per cycle with out_ready held high, i.e. one word per DEPTH cycles.
- Counter width: $clog2(DEPTH), minimum 1 bit. The counter never wraps past DEPTH-1.

Optional Feature:
- Macro: BEAT_SERIALIZER_MSB_FIRST_EN.
- Defined: beat order is reversed. The first beat emitted is in_data[(DEPTH-1)*WIDTH +: WIDTH] and the last is in_data[WIDTH-1:0].
- Not defined (default): LSB-first order as described under Behaviour.
- Handshake, latency and out_last timing are identical in both builds.

Test Plan (DEPTH = 4, WIDTH = 4):
- Reset: rst pulsed high between clock edges -> out_valid, out_last and busy go 0 immediately; in_ready = 1 once rst is released.
- Single word, in_data = 16'h4321, out_ready = 1 -> out_data 1,2,3,4 on four consecutive cycles starting 1 cycle after accept; out_last = 1 only on beat 4; then out_valid = 0.
- Back-to-back, 16'h4321 then 16'h8765 presented continuously, out_ready = 1 -> eight consecutive beats 1..8 with no gap; in_ready high only in the beat-4 cycle; out_last on beats 4 and 8.
- Backpressure: out_ready low for 3 cycles while beat 2 is presented -> out_data stays 2 with out_valid = 1 and in_ready = 0; a new in_valid is ignored; the sequence then resumes 3,4.
- Mid-word reset: rst asserted while beat 2 is presented, then word 16'hCBA9 sent -> output is 9,A,B,C; no beat from the old word ever appears.
- BEAT_SERIALIZER_MSB_FIRST_EN defined, in_data = 16'h4321 -> beats 4,3,2,1 with out_last on beat 1.
